// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART transmitter.
// Holds the FSM state enum, the parity-mode codes and the frame-length and parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Zero-extension to 9 bits leaves the XOR reduction unchanged.
  function automatic logic parity_of(input logic [8:0] word, input int parity_mode);
    return (parity_mode == PAR_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Word FIFO in front of the UART serialiser.
// full/empty/count come from the registered count only, so a same-cycle pop never bypasses.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter: FIFO-buffered words sent as start/data/parity/stop frames.
// Frames are chained without an idle gap whenever another word is already queued.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_framed: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_framed: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("uart_tx_framed: CLKS_PER_BIT must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_framed: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (FRAME_BITS < 7 || FRAME_BITS > 13) begin : g_bad_frame
    $error("uart_tx_framed: frame length out of range");
  end

  tx_state_e                  state, state_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic [3:0]                 bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0]       shreg, shreg_n;
  logic                       par_bit, par_bit_n;
  logic                       tx_n;
  logic                       frame_done_n;
  logic                       boundary;
  logic                       load;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [DATA_BITS-1:0]       fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid && in_ready),
    .pop     (fifo_pop),
    .wr_data (in_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != ST_IDLE) || (fifo_count != '0);
  assign boundary = (cnt == LAST_CNT);

  always_comb begin
    state_n   = state;
    cnt_n     = boundary ? '0 : cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    tx_n      = tx;
    load      = 1'b0;
    fifo_pop  = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (boundary) begin
          state_n   = ST_DATA;
          tx_n      = shreg[0];
          bit_idx_n = '0;
        end
      end
      ST_DATA: begin
        if (boundary) begin
          shreg_n = shreg >> 1;
          if (bit_idx == LAST_DATA) begin
            bit_idx_n = '0;
            if (PARITY_MODE != PAR_NONE) begin
              state_n = ST_PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            tx_n      = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (boundary) begin
          state_n   = ST_STOP;
          tx_n      = 1'b1;
          bit_idx_n = '0;
        end
      end
      ST_STOP: begin
        if (boundary) begin
          if (bit_idx == LAST_STOP) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_n = ST_IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // Shared pop-and-start path for both the idle case and back-to-back chaining.
    if (load) begin
      fifo_pop  = 1'b1;
      shreg_n   = fifo_rd_data;
      par_bit_n = parity_of(9'(fifo_rd_data), PARITY_MODE);
      tx_n      = 1'b0;
      bit_idx_n = '0;
      cnt_n     = '0;
      state_n   = ST_START;
    end

    frame_done_n = (state_n == ST_STOP) && (bit_idx_n == LAST_STOP) && (cnt_n == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      tx         <= tx_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: three instances cover even/odd parity and the 7N2, 1-clock variant.
// Expected serial frames are hand-written bit strings in transmission order.
module tb_uart_tx_framed;

  logic       clk;
  logic       rst;
  logic [7:0] in_data_a, in_data_o;
  logic [6:0] in_data_v;
  logic       in_valid_a, in_valid_o, in_valid_v;
  logic       in_ready_a, in_ready_o, in_ready_v;
  logic       tx_a, tx_o, tx_v;
  logic       busy_a, busy_o, busy_v;
  logic       fd_a, fd_o, fd_v;

  int   compared;
  int   mismatched;
  int   sel;
  logic tx_m, fd_m, busy_m, rdy_m;

  uart_tx_framed #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .tx(tx_a), .busy(busy_a), .frame_done(fd_a));

  uart_tx_framed #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_o (
    .clk(clk), .rst(rst), .in_data(in_data_o), .in_valid(in_valid_o), .in_ready(in_ready_o),
    .tx(tx_o), .busy(busy_o), .frame_done(fd_o));

  uart_tx_framed #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut_v (
    .clk(clk), .rst(rst), .in_data(in_data_v), .in_valid(in_valid_v), .in_ready(in_ready_v),
    .tx(tx_v), .busy(busy_v), .frame_done(fd_v));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    tx_m = tx_a; fd_m = fd_a; busy_m = busy_a; rdy_m = in_ready_a;
    case (sel)
      1: begin tx_m = tx_o; fd_m = fd_o; busy_m = busy_o; rdy_m = in_ready_o; end
      2: begin tx_m = tx_v; fd_m = fd_v; busy_m = busy_v; rdy_m = in_ready_v; end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int s, input logic [8:0] d, input logic v);
    case (s)
      1:       begin in_data_o = d[7:0]; in_valid_o = v; end
      2:       begin in_data_v = d[6:0]; in_valid_v = v; end
      default: begin in_data_a = d[7:0]; in_valid_a = v; end
    endcase
  endtask

  // One-cycle handshake from idle; returns at the first cycle of the start bit.
  task automatic sendWithLatency(input string tag, input logic [8:0] d);
    applyStimulus(sel, d, 1'b1);
    @(negedge clk);
    applyStimulus(sel, 9'h0, 1'b0);
    checkOutput({tag, "_lat_n1_tx"}, tx_m, 1'b1);
    checkOutput({tag, "_lat_n1_busy"}, busy_m, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_lat_n2_tx"}, tx_m, 1'b0);
  endtask

  task automatic checkFrame(input string tag, input string bits, input int cpb);
    int len;
    len = bits.len();
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < cpb; c++) begin
        checkOutput($sformatf("%s_tx_b%0d_c%0d", tag, i, c), tx_m, bits.getc(i) == "1");
        checkOutput($sformatf("%s_fd_b%0d_c%0d", tag, i, c), fd_m, (i == len - 1) && (c == cpb - 1));
        checkOutput($sformatf("%s_busy_b%0d_c%0d", tag, i, c), busy_m, 1'b1);
        @(negedge clk);
      end
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_idle_busy"}, busy_m, 1'b0);
    checkOutput({tag, "_idle_tx"}, tx_m, 1'b1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] fw [5];
    string      fs [5];
    logic       prev_fd, got, seen_low, seen_fd;

    fw = '{8'h80, 8'hFF, 8'h3C, 8'h96, 8'h4A};
    fs = '{"00000000111", "01111111101", "00011110001", "00110100101", "00101001011"};

    compared = 0; mismatched = 0; sel = 0;
    rst = 1'b1;
    in_data_a = '0; in_data_o = '0; in_data_v = '0;
    in_valid_a = 1'b0; in_valid_o = 1'b0; in_valid_v = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    checkOutput("rst_tx_a", tx_a, 1'b1);
    checkOutput("rst_busy_a", busy_a, 1'b0);
    checkOutput("rst_fd_a", fd_a, 1'b0);
    checkOutput("rst_ready_a", in_ready_a, 1'b1);
    checkOutput("rst_tx_v", tx_v, 1'b1);
    checkOutput("rst_ready_o", in_ready_o, 1'b1);

    // Single even-parity frame, 0xA5
    sel = 0;
    sendWithLatency("a5", 9'h0A5);
    checkFrame("a5", "01010010101", 4);
    checkIdle("a5");

    // 0x07 with odd parity, then even parity
    sel = 1;
    sendWithLatency("o07", 9'h007);
    checkFrame("o07", "01110000001", 4);
    checkIdle("o07");
    sel = 0;
    sendWithLatency("e07", 9'h007);
    checkFrame("e07", "01110000011", 4);
    checkIdle("e07");

    // 7 data bits, no parity, 2 stop bits, one clock per bit
    sel = 2;
    sendWithLatency("v55", 9'h055);
    checkFrame("v55", "0101010111", 1);
    checkIdle("v55");

    // Back-to-back frames
    sel = 0;
    applyStimulus(0, 9'h011, 1'b1);
    @(negedge clk);
    applyStimulus(0, 9'h022, 1'b1);
    @(negedge clk);
    checkOutput("b2b_lat_tx", tx_m, 1'b0);
    applyStimulus(0, 9'h033, 1'b1);
    fork
      begin @(posedge clk); #1; in_valid_a = 1'b0; end
    join_none
    checkFrame("b2b_11", "01000100001", 4);
    checkFrame("b2b_22", "00100010001", 4);
    checkFrame("b2b_33", "01100110001", 4);
    checkIdle("b2b");

    // FIFO full while a frame is active
    sendWithLatency("w0", 9'h001);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, {1'b0, fw[k]}, 1'b1);
      checkOutput($sformatf("full_rdy%0d", k), rdy_m, k < 4);
      @(negedge clk);
    end
    prev_fd = 1'b0;
    got     = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rdy_m) begin
        got = 1'b1;
        break;
      end
      prev_fd = fd_m;
      @(negedge clk);
    end
    checkOutput("full_wait_ready", got, 1'b1);
    checkOutput("full_ready_after_pop", prev_fd, 1'b1);
    fork
      begin @(posedge clk); #1; in_valid_a = 1'b0; end
    join_none
    for (int k = 0; k < 5; k++) checkFrame($sformatf("full_w%0d", k + 1), fs[k], 4);
    checkIdle("full");

    // Reset during data bit 3 with two words queued
    sendWithLatency("r0f", 9'h00F);
    applyStimulus(0, 9'h0AA, 1'b1);
    @(negedge clk);
    applyStimulus(0, 9'h0BB, 1'b1);
    @(negedge clk);
    applyStimulus(0, 9'h000, 1'b0);
    repeat (15) @(negedge clk);
    checkOutput("pre_rst_bit3_tx", tx_m, 1'b1);
    checkOutput("pre_rst_busy", busy_m, 1'b1);
    rst = 1'b1;
    applyStimulus(0, 9'h0CC, 1'b1);
    @(negedge clk);
    checkOutput("mid_rst_tx", tx_m, 1'b1);
    checkOutput("mid_rst_busy", busy_m, 1'b0);
    checkOutput("mid_rst_ready", rdy_m, 1'b1);
    checkOutput("mid_rst_fd", fd_m, 1'b0);
    rst = 1'b0;
    applyStimulus(0, 9'h000, 1'b0);
    seen_low = 1'b0;
    seen_fd  = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (!tx_m) seen_low = 1'b1;
      if (fd_m)  seen_fd  = 1'b1;
    end
    checkOutput("post_rst_no_tx", seen_low, 1'b0);
    checkOutput("post_rst_no_fd", seen_fd, 1'b0);
    checkOutput("post_rst_busy", busy_m, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
